// File: rtl/div24u_seq_restoring.sv
// -----------------------------------------------------------------------------
// div24u_seq_restoring
//   Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor
//   gives a W-bit quotient and a W-bit remainder. The divider produces one
//   quotient bit per cycle and has valid/ready handshakes on both sides.
//   TRUNC forces dividend LSBs to zero at accept, which makes approximate
//   variants of the divider.
//
// Parameters
//   W      operand width (dividend is 2W bits)
//   TRUNC  number of dividend LSBs zeroed at accept (0 = exact)
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   IN_VALID   dividend/divisor valid
//   IN_READY   divider idle (combinational from state)
//   A          dividend, 2W bits unsigned
//   B          divisor, W bits unsigned
//   OUT_VALID  result valid (registered)
//   OUT_READY  consumer accepts result
//   Q          quotient (registered)
//   R          remainder (registered)
//   DIV0       divisor was zero
//   OVF        quotient would not fit in W bits
// -----------------------------------------------------------------------------
module div24u_seq_restoring #(
  parameter int unsigned W     = 12,
  parameter int unsigned TRUNC = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2*W-1:0]   A,
  input  logic [W-1:0]     B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [W-1:0]     Q,
  output logic [W-1:0]     R,
  output logic             DIV0,
  output logic             OVF
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    alo_q;      // low half of the latched dividend, consumed MSB first
  logic [W-1:0]    b_q;
  logic [W:0]      rem_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    q_q;
  logic [W-1:0]    r_q;
  logic            div0_q;
  logic            ovf_q;
  logic            out_valid_q;

  // Accept-side datapath
  logic [2*W-1:0]  trunc_mask;
  logic [2*W-1:0]  a_m;
  logic [W-1:0]    a_hi;
  logic [W-1:0]    a_lo;

  always_comb begin
    trunc_mask = '0;
    for (int unsigned i = 0; i < 2*W; i++) begin
      trunc_mask[i] = (i >= TRUNC);
    end
    a_m  = A & trunc_mask;
    a_hi = a_m[2*W-1:W];
    a_lo = a_m[W-1:0];
  end

  // One restoring step: shift in the next dividend bit, trial-subtract at W+1 bits
  logic [W:0]      t_d;
  logic            qbit_d;
  logic [W:0]      rem_d;

  always_comb begin
    t_d    = {rem_q[W-1:0], alo_q[cnt_q]};
    qbit_d = (t_d >= {1'b0, b_q});
    rem_d  = qbit_d ? (t_d - {1'b0, b_q}) : t_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      alo_q       <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            alo_q  <= a_lo;
            b_q    <= B;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (B == '0) begin
              q_q     <= '1;
              r_q     <= a_lo;
              div0_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (a_hi >= B) begin
              q_q     <= '1;
              r_q     <= '0;
              ovf_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rem_q   <= {1'b0, a_hi};
              cnt_q   <= CW'(W - 1);
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          rem_q <= rem_d;
          q_q   <= {q_q[W-2:0], qbit_d};
          if (cnt_q == '0) begin
            r_q     <= rem_d[W-1:0];
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_DONE: begin
          // OUT_VALID rises one cycle after entering DONE, so every path
          // sees the same registered result/valid relationship.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = out_valid_q;
  assign Q         = q_q;
  assign R         = r_q;
  assign DIV0      = div0_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_div24u_seq_restoring.sv
module tb_div24u_seq_restoring;

  localparam int N_RAND = 300;
  localparam int N_PROD = 2000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, DIV0, OVF;
  logic [23:0] A;
  logic [11:0] B, Q, R;

  // Second instance exercising dividend truncation
  logic        IN_VALID1, IN_READY1, OUT_VALID1, DIV0_1, OVF1;
  logic [23:0] A1;
  logic [11:0] B1, Q1, R1;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  div24u_seq_restoring #(.W(12), .TRUNC(0)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Q(Q), .R(R), .DIV0(DIV0), .OVF(OVF)
  );

  div24u_seq_restoring #(.W(12), .TRUNC(4)) dut_t4 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID1), .IN_READY(IN_READY1),
    .A(A1), .B(B1), .OUT_VALID(OUT_VALID1), .OUT_READY(1'b1),
    .Q(Q1), .R(R1), .DIV0(DIV0_1), .OVF(OVF1)
  );

  // Reference: {Q, R, DIV0, OVF} from plain integer division
  function automatic logic [25:0] model(input logic [23:0] a, input logic [11:0] b, input int trunc);
    logic [23:0] am;
    am = (a >> trunc) << trunc;
    if (b == 12'd0) return {12'hFFF, am[11:0], 2'b10};
    if (am[23:12] >= b) return {12'hFFF, 12'h000, 2'b01};
    return {12'(am / b), 12'(am % b), 2'b00};
  endfunction

  // Present one operand pair, wait for accept, then count edges until OUT_VALID
  task automatic xfer(input logic [23:0] a, input logic [11:0] b, output int lat);
    int guard;
    A = a; B = b; IN_VALID = 1'b1;
    guard = 0;
    @(negedge CLK);
    while (!IN_READY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!OUT_VALID && lat < 100);
  endtask

  task automatic handshake();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: IN_READY=%b OUT_VALID=%b, want 1/0", IN_READY, OUT_VALID);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({IN_READY, OUT_VALID, Q, R, DIV0, OVF} !== {1'b1, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b Q=%h R=%h D0=%b OVF=%b, want 1 0 000 000 0 0",
               IN_READY, OUT_VALID, Q, R, DIV0, OVF);
    end
  endtask

  task automatic test_directed();
    int lat;
    logic [23:0] ta [3];
    logic [11:0] tb [3];
    int          tl [3];
    logic [25:0] te [3];
    ta[0] = 24'h0F4240; tb[0] = 12'd1000;  tl[0] = 13; te[0] = {12'd1000, 12'd0, 2'b00};
    ta[1] = 24'h123456; tb[1] = 12'd0;     tl[1] = 1;  te[1] = {12'hFFF, 12'h456, 2'b10};
    ta[2] = 24'h800000; tb[2] = 12'h800;   tl[2] = 1;  te[2] = {12'hFFF, 12'h000, 2'b01};
    for (int i = 0; i < 3; i++) begin
      xfer(ta[i], tb[i], lat);
      checks++;
      if (lat !== tl[i]) begin
        failures++;
        $display("FAIL directed%0d_latency: got %0d, want %0d", i, lat, tl[i]);
      end
      checks++;
      if ({Q, R, DIV0, OVF} !== te[i]) begin
        failures++;
        $display("FAIL directed%0d_result: Q=%h R=%h D0=%b OVF=%b, want Q=%h R=%h D0=%b OVF=%b",
                 i, Q, R, DIV0, OVF, te[i][25:14], te[i][13:2], te[i][1], te[i][0]);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    xfer(24'h000064, 12'd7, lat);
    A = 24'h0F4240; B = 12'd1000; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({OUT_VALID, IN_READY, Q, R} !== {1'b1, 1'b0, 12'd14, 12'd2}) begin
        failures++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b Q=%0d R=%0d, want 1 0 14 2",
                 i, OUT_VALID, IN_READY, Q, R);
      end
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    checks++;
    if ({IN_READY, OUT_VALID, Q, R} !== {1'b1, 1'b0, 12'd14, 12'd2}) begin
      failures++;
      $display("FAIL bp_release: rdy=%b vld=%b Q=%0d R=%0d, want 1 0 14 2", IN_READY, OUT_VALID, Q, R);
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midop();
    int lat, seen;
    A = 24'h0F4240; B = 12'd3; IN_VALID = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL midop_reset: vld=%b rdy=%b, want 0 1", OUT_VALID, IN_READY);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midop_stale: OUT_VALID high %0d cycles, want 0", seen);
    end
    xfer(24'h0F4240, 12'd1000, lat);
    checks++;
    if ({Q, R, DIV0, OVF} !== {12'd1000, 12'd0, 2'b00} || lat !== 13) begin
      failures++;
      $display("FAIL midop_after: Q=%0d R=%0d lat=%0d, want 1000 0 13", Q, R, lat);
    end
    handshake();
  endtask

  task automatic test_trunc();
    int lat;
    logic [23:0] ta [2];
    logic [11:0] tb [2];
    logic [25:0] exp;
    ta[0] = 24'h00FFFF; tb[0] = 12'h010;
    ta[1] = 24'h00001F; tb[1] = 12'd3;
    for (int i = 0; i < 2; i++) begin
      A1 = ta[i]; B1 = tb[i]; IN_VALID1 = 1'b1;
      @(posedge CLK); #1;
      IN_VALID1 = 1'b0;
      lat = 0;
      do begin
        @(posedge CLK); #1;
        lat++;
      end while (!OUT_VALID1 && lat < 100);
      exp = model(ta[i], tb[i], 4);
      checks++;
      if ({Q1, R1, DIV0_1, OVF1} !== exp || lat !== 13) begin
        failures++;
        $display("FAIL trunc%0d: Q=%h R=%h D0=%b OVF=%b lat=%0d, want Q=%h R=%h D0=%b OVF=%b lat=13",
                 i, Q1, R1, DIV0_1, OVF1, lat, exp[25:14], exp[13:2], exp[1], exp[0]);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random_model();
    int lat, want_lat;
    logic [23:0] a;
    logic [11:0] b;
    logic [25:0] exp;
    int bad = 0;
    OUT_READY = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      a = 24'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 12'd0;
        1:       b = 12'($urandom_range(1, 15));
        default: b = 12'($urandom_range(1, 4095));
      endcase
      if ($urandom_range(0, 1) == 1 && b != 0) a[23:12] = 12'($urandom_range(0, int'(b) - 1));
      exp = model(a, b, 0);
      want_lat = (exp[1:0] == 2'b00) ? 13 : 1;
      xfer(a, b, lat);
      checks++;
      if ({Q, R, DIV0, OVF} !== exp || lat !== want_lat) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random_div: A=%h B=%h got Q=%h R=%h D0=%b OVF=%b lat=%0d, want Q=%h R=%h D0=%b OVF=%b lat=%0d",
                   a, b, Q, R, DIV0, OVF, lat, exp[25:14], exp[13:2], exp[1], exp[0], want_lat);
      end
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    logic [11:0] x, y;
    int start_t, cycles;
    OUT_READY = 1'b1;
    start_t = $time;
    for (int i = 0; i < N_PROD; i++) begin
      x = 12'($urandom_range(0, 4095));
      y = 12'($urandom_range(1, 4095));
      xfer(24'(x) * 24'(y), y, lat);
      checks++;
      if (Q !== x || R !== 12'd0 || DIV0 !== 1'b0 || OVF !== 1'b0 || lat !== 13) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL product_div: x=%0d y=%0d got Q=%0d R=%0d D0=%b OVF=%b lat=%0d, want Q=%0d R=0 lat=13",
                   x, y, Q, R, DIV0, OVF, lat, x);
      end
    end
    // Steady-state throughput: 13 cycles to valid, handshake, one idle/accept cycle
    cycles = ($time - start_t) / 10;
    checks++;
    if (cycles > N_PROD * 15 + 2) begin
      failures++;
      $display("FAIL b2b_throughput: %0d cycles, want at most %0d", cycles, N_PROD * 15 + 2);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0;
    IN_VALID1 = 1'b0; A1 = '0; B1 = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_trunc();
    test_random_model();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
